// File: rtl/updown_pkg.sv
// Shared types for the programmable up/down counter: counting modes and one-shot FSM states.
package updown_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } cnt_mode_e;

   typedef enum logic [1:0] {
      OS_IDLE = 2'b00,
      OS_RUN  = 2'b01,
      OS_DONE = 2'b10
   } os_state_e;

endpackage

// File: rtl/updown_next.sv
// Combinational next-count arithmetic: one wrap-or-saturate step of size s within 0..lim.
module updown_next #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] lim,
   input  logic [WIDTH:0]   s,
   input  logic             up_n,
   input  logic             sat,
   output logic [WIDTH-1:0] q_next,
   output logic             hit
);

   localparam logic [WIDTH-1:0] ONE = 1;

   logic [WIDTH:0]   q_x;
   logic [WIDTH:0]   lim_x;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] s_lo;

   assign q_x   = {1'b0, q};
   assign lim_x = {1'b0, lim};
   assign sum   = q_x + s;
   // Wrapped results always land in 0..lim, so modulo-2^WIDTH arithmetic is exact.
   assign s_lo  = s[WIDTH-1:0];

   always_comb begin
      q_next = q;
      hit    = 1'b0;
      if (up_n) begin
         if (sat) begin
            if (sum >= lim_x) begin
               q_next = lim;
               hit    = (q < lim);
            end else begin
               q_next = sum[WIDTH-1:0];
            end
         end else if (sum > lim_x) begin
            q_next = q + s_lo - lim - ONE;
            hit    = 1'b1;
         end else begin
            q_next = sum[WIDTH-1:0];
         end
      end else begin
         if (sat) begin
            if (q_x <= s) begin
               q_next = '0;
               hit    = (q != '0);
            end else begin
               q_next = q - s_lo;
            end
         end else if (q_x >= s) begin
            q_next = q - s_lo;
         end else begin
            q_next = q + lim + ONE - s_lo;
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/updown_counter_mod.sv
// Programmable up/down counter with wrap, saturate and one-shot modes, parallel load,
// terminal-count pulse and sticky overflow flag. All outputs are registered.
module updown_counter_mod
   import updown_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              up_n,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  lim,
   input  logic [STEP_W-1:0] step,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              start,
   input  logic              clr_ovf,
   output logic [WIDTH-1:0]  q,
   output logic              tc,
   output logic              busy,
   output logic              done,
   output logic              ovf
);

   localparam logic [WIDTH:0] ONE_X = 1;

   cnt_mode_e        mode_e;
   os_state_e        state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             is_os;
   logic             sat;
   logic [WIDTH:0]   step_x;
   logic [WIDTH:0]   lim_p1;
   logic [WIDTH:0]   s;
   logic [WIDTH-1:0] q_next;
   logic             hit;
   logic             count_ok;
   logic             wrap_evt;

   assign mode_e = cnt_mode_e'(mode);
   assign is_os  = (mode_e == MODE_ONESHOT);
   assign sat    = (mode_e == MODE_SAT) || is_os;

   // Step is clamped to lim+1 so a single step never travels more than one full lap.
   assign step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
   assign lim_p1 = {1'b0, lim} + ONE_X;
   assign s      = (step_x > lim_p1) ? lim_p1 : step_x;

   updown_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .q      (q_q),
      .lim    (lim),
      .s      (s),
      .up_n   (up_n),
      .sat    (sat),
      .q_next (q_next),
      .hit    (hit)
   );

   assign count_ok = en && (!is_os || (state_q == OS_RUN));

   always_comb begin
      q_d      = q_q;
      tc_d     = 1'b0;
      state_d  = state_q;
      wrap_evt = 1'b0;
      if (load) begin
         q_d = (load_val > lim) ? lim : load_val;
      end else if (start && is_os) begin
         q_d     = up_n ? '0 : lim;
         state_d = OS_RUN;
      end else if (count_ok) begin
         if (q_q > lim) begin
            q_d = lim;
         end else if (s != '0) begin
            q_d  = q_next;
            tc_d = hit;
            if (is_os && hit) begin
               state_d = OS_DONE;
            end
            wrap_evt = hit && !sat;
         end
      end
      if (!is_os) begin
         state_d = OS_IDLE;
      end
      ovf_d  = wrap_evt || (ovf_q && !clr_ovf);
      busy_d = (state_d == OS_RUN);
      done_d = (state_d == OS_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q     <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         state_q <= OS_IDLE;
      end else begin
         q_q     <= q_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         state_q <= state_d;
      end
   end

   assign q    = q_q;
   assign tc   = tc_q;
   assign ovf  = ovf_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: hand-computed expectations checked one edge at a time.
module tb_updown_counter_mod;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       up_n;
   logic [1:0] mode;
   logic [7:0] lim;
   logic [3:0] step;
   logic       load;
   logic [7:0] load_val;
   logic       start;
   logic       clr_ovf;
   logic [7:0] q;
   logic       tc;
   logic       busy;
   logic       done;
   logic       ovf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   updown_counter_mod #(
      .WIDTH  (8),
      .STEP_W (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up_n     (up_n),
      .mode     (mode),
      .lim      (lim),
      .step     (step),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .clr_ovf  (clr_ovf),
      .q        (q),
      .tc       (tc),
      .busy     (busy),
      .done     (done),
      .ovf      (ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] eq, input logic etc,
                          input logic ebusy, input logic edone, input logic eovf);
      chk({tag, ".q"}, {24'd0, q}, {24'd0, eq});
      chk({tag, ".tc"}, {31'd0, tc}, {31'd0, etc});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, ebusy});
      chk({tag, ".done"}, {31'd0, done}, {31'd0, edone});
      chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
      $display("step %-12s q=%0d tc=%0b busy=%0b done=%0b ovf=%0b", tag, q, tc, busy, done, ovf);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; up_n = 1'b1; mode = 2'b00; lim = 8'd200; step = 4'd1;
      load = 1'b0; load_val = 8'd0; start = 1'b0; clr_ovf = 1'b0;
      tick();
      chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset in the middle of a count
      rst_n = 1'b1; load = 1'b1; load_val = 8'd37;
      tick();
      chk_all("load37", 8'd37, 1'b0, 1'b0, 1'b0, 1'b0);
      load = 1'b0; en = 1'b1; rst_n = 1'b0;
      tick();
      chk_all("rst_mid", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1; en = 1'b0;

      // WRAP up, lim 9, step 3
      lim = 8'd9; step = 4'd3; en = 1'b1;
      tick(); chk_all("wup1", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); chk_all("wup2", 8'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); chk_all("wup3", 8'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); chk_all("wup_wrap", 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      en = 1'b0; clr_ovf = 1'b1;
      tick(); chk_all("clr_ovf", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      clr_ovf = 1'b0; load = 1'b1; load_val = 8'd9;
      tick(); chk_all("load9", 8'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      load = 1'b0; en = 1'b1; clr_ovf = 1'b1;
      tick(); chk_all("clr_vs_wrap", 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      en = 1'b0; clr_ovf = 1'b0;

      // WRAP down, lim 9
      load = 1'b1; load_val = 8'd1;
      tick(); chk_all("load1", 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      load = 1'b0; up_n = 1'b0; step = 4'd4; en = 1'b1;
      tick(); chk_all("wdn_wrap", 8'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      step = 4'd15;
      tick(); chk_all("wdn_clamp", 8'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      en = 1'b0;

      // SAT up, lim 200, step 15
      mode = 2'b01; up_n = 1'b1; lim = 8'd200; step = 4'd15; load = 1'b1; load_val = 8'd190;
      tick(); chk_all("load190", 8'd190, 1'b0, 1'b0, 1'b0, 1'b1);
      load = 1'b0; en = 1'b1;
      tick(); chk_all("sat_hit", 8'd200, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(); chk_all("sat_hold", 8'd200, 1'b0, 1'b0, 1'b0, 1'b1);
      en = 1'b0; load = 1'b1; load_val = 8'd250;
      tick(); chk_all("load_clamp", 8'd200, 1'b0, 1'b0, 1'b0, 1'b1);
      load = 1'b0; lim = 8'd50; en = 1'b1;
      tick(); chk_all("lim_lower", 8'd50, 1'b0, 1'b0, 1'b0, 1'b1);
      en = 1'b0;

      // ONESHOT down, lim 5, step 2
      mode = 2'b10; up_n = 1'b0; lim = 8'd5; step = 4'd2; start = 1'b1;
      tick(); chk_all("os_start", 8'd5, 1'b0, 1'b1, 1'b0, 1'b1);
      start = 1'b0; en = 1'b1;
      tick(); chk_all("os_3", 8'd3, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(); chk_all("os_1", 8'd1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(); chk_all("os_end", 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick(); chk_all("os_done", 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      en = 1'b0; start = 1'b1;
      tick(); chk_all("os_rearm", 8'd5, 1'b0, 1'b1, 1'b0, 1'b1);
      start = 1'b0; en = 1'b1;
      tick(); chk_all("os_run2", 8'd3, 1'b0, 1'b1, 1'b0, 1'b1);
      en = 1'b0; start = 1'b1;
      tick(); chk_all("os_restart", 8'd5, 1'b0, 1'b1, 1'b0, 1'b1);
      start = 1'b0; mode = 2'b00;
      tick(); chk_all("os_leave", 8'd5, 1'b0, 1'b0, 1'b0, 1'b1);

      // priority: load beats start beats en, FSM stays IDLE
      mode = 2'b10; load = 1'b1; start = 1'b1; en = 1'b1; load_val = 8'd3;
      tick(); chk_all("prio", 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      load = 1'b0; start = 1'b0;
      tick(); chk_all("idle_ign_en", 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);

      // step 0 holds in WRAP
      mode = 2'b00; step = 4'd0; up_n = 1'b1;
      tick(); chk_all("step0", 8'd3, 1'b0, 1'b0, 1'b0, 1'b1);

      // lim 0: clamp first, then wrap every enabled cycle; SAT gives no tc
      clr_ovf = 1'b1; en = 1'b0;
      tick(); chk_all("clr2", 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      clr_ovf = 1'b0; lim = 8'd0; step = 4'd5; en = 1'b1;
      tick(); chk_all("lim0_clamp", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); chk_all("lim0_wrap", 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      up_n = 1'b0;
      tick(); chk_all("lim0_wdn", 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      mode = 2'b01;
      tick(); chk_all("lim0_sat", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

      // reserved mode behaves as WRAP
      mode = 2'b11; lim = 8'd9; up_n = 1'b1; step = 4'd4; en = 1'b0; load = 1'b1; load_val = 8'd8;
      clr_ovf = 1'b1;
      tick(); chk_all("rsvd_load", 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      load = 1'b0; clr_ovf = 1'b0; en = 1'b1;
      tick(); chk_all("rsvd_wrap", 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised successor to the basic up/down counter. Adds:
- a runtime modulus limit and a programmable step;
- wrap, saturate and one-shot modes, with the one-shot mode controlled by a small FSM;
- synchronous parallel load, a terminal-count pulse and a sticky overflow flag.

Used as a programmable timer/position counter in datapath and control blocks.

Parameters:
WIDTH, 8, counter width; q ranges 0..lim.
STEP_W, 4, width of the step input (STEP_W <= WIDTH).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  count enable
up_n  in  1  1 = count up, 0 = count down
mode  in  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (treated as WRAP)
lim  in  WIDTH  inclusive upper bound of the count range
step  in  STEP_W  increment/decrement magnitude
load  in  1  parallel load strobe
load_val  in  WIDTH  load value
start  in  1  ONESHOT arm pulse
clr_ovf  in  1  clears the ovf flag
q  out  WIDTH  count value
tc  out  1  registered 1-cycle terminal-count pulse
busy  out  1  ONESHOT: in RUN
done  out  1  ONESHOT: in DONE
ovf  out  1  sticky: a wrap occurred

Behaviour:
- Reset (rst_n=0 at a clk edge): q=0, tc=0, busy=0, done=0, ovf=0, FSM=IDLE. Reset overrides everything, including mid-count and mid-ONESHOT.
- All outputs are registered. Inputs sampled at edge N take effect on q, tc and flags at edge N.
- Priority per cycle: rst_n > load > start > en.
- Load: q <= min(load_val, lim); tc=0; FSM and ovf unchanged.
- Effective step: s = min(step, lim+1), computed in WIDTH+1 bits. step=0 means hold: q unchanged, tc=0.
- If q > lim (lim lowered at runtime), an enabled count cycle sets q <= lim with tc=0. No arithmetic is applied that cycle.
- WRAP, up: sum = q+s (WIDTH+1 bits). If sum > lim, q <= sum-lim-1, tc=1, ovf=1; else q <= sum.
- WRAP, down: if q >= s, q <= q-s; else q <= q+lim+1-s, tc=1, ovf=1.
- SAT, up: q <= min(q+s, lim). tc=1 only on the cycle q becomes lim from below. Holding at lim gives tc=0.
- SAT, down: q <= max(q-s, 0), with tc on reaching 0 from above. The rule mirrors SAT up.
- ONESHOT FSM, states IDLE, RUN, DONE:
  - IDLE: q holds and en is ignored. start -> RUN, with q <= 0 if up_n=1, else q <= lim.
  - RUN: busy=1. Counts with SAT arithmetic while en. On the step that reaches the terminal value (lim when up, 0 when down), tc=1 and the FSM goes to DONE.
  - DONE: done=1, q holds, en is ignored. start -> RUN, reinitialising q as above.
  - start while in RUN restarts the count (reinitialises q) and gives tc=0.
  - A mode change away from ONESHOT forces the FSM to IDLE on the next edge.
- busy and done are driven only in ONESHOT mode. They are 0 in the other modes.
- ovf is set only by a WRAP event. clr_ovf clears it; if a wrap occurs in the same cycle, set wins.
- lim=0: the counter stays at q=0. WRAP gives tc=1 and ovf=1 on every enabled nonzero step. SAT gives tc=0.
- up_n, mode, lim and step may change on any cycle and take effect immediately.

Decomposition:
- Package updown_pkg holds:
  - typedef enum logic[1:0] cnt_mode_e {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD};
  - typedef enum logic[1:0] os_state_e {OS_IDLE, OS_RUN, OS_DONE}.
- Sub-module updown_next is purely combinational. Inputs: q, lim, s, up_n, sat. Outputs: q_next, hit (boundary reached or wrapped). It is instantiated once.
- The top level holds the registers, the priority logic and the FSM.

Test Plan:
All scenarios use WIDTH=8 and STEP_W=4.
1. Reset mid-count: q=37, then rst_n=0 for 1 cycle with en=1 -> q=0, tc=0, ovf=0, FSM IDLE.
2. WRAP up, lim=9, step=3, from q=0: q goes 3, 6, 9, then 2 with tc=1 on that cycle and ovf=1. clr_ovf -> ovf=0. clr_ovf together with a wrap -> ovf stays 1.
3. WRAP down, lim=9, step=4, from q=1: q=7 with tc=1. Then step=15 (clamped to s=10) from q=7: q=7 with tc=1.
4. SAT up, lim=200, step=15, from q=190: q=200 with tc=1, next cycle q=200 with tc=0. Then load with load_val=250 -> q=200. Then lim=50 with en=1 -> q=50, tc=0.
5. ONESHOT down, lim=5, step=2:
   - start -> q=5, busy=1; then q=3, 1, 0, with tc=1 on the cycle q becomes 0;
   - then done=1 and busy=0; further en leaves q=0;
   - start -> q=5, busy=1.
6. Priority: load=1, start=1, en=1 in the same cycle in ONESHOT IDLE -> q=load_val and FSM stays IDLE. step=0 with en=1 in WRAP -> q holds, tc=0.
